exception_ctrl: RTL
===================

Name: exception_ctrl

Overview:
- Commit-stage exception/interrupt sequencer that drives the CSR file's exception and ertn inputs.
- Samples the committing instruction's exception status, the pending-interrupt state from CSR outputs, and ertn.
- Picks one event per instruction boundary, pulses the CSR update, and sequences a pipeline flush plus a front-end redirect to EENTRY, TLBRENTRY or ERA.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after an accepted event (legal range 1..15).
- CAUSE_W, 7, width of the exception cause code; encodings are the `EXCEPTION_* codes in define.v.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- commit_valid  in  1  an instruction is at commit this cycle
- commit_pc  in  32  PC of committing instruction
- commit_exc_valid  in  1  committing instruction raised an exception
- commit_exc_cause  in  CAUSE_W  its cause code
- commit_exc_addr  in  32  faulting virtual address (BADV source)
- commit_is_ertn  in  1  committing instruction is ertn
- commit_ready  out  1  controller accepts commit this cycle
- crmd_ie  in  1  CRMD.IE from CSR
- ecfg_lie  in  12  ECFG local interrupt enables
- estat_is  in  12  ESTAT interrupt status
- eentry_va  in  32  exception entry address
- tlbrentry_pa  in  32  TLB-refill entry address
- era_pc  in  32  ERA from CSR
- is_exception  out  1  one-cycle pulse to CSR
- exception_cause  out  CAUSE_W  cause to CSR
- exception_pc  out  32  PC to CSR
- exception_addr  out  32  BADV value to CSR
- is_ertn  out  1  one-cycle pulse to CSR
- flush  out  1  pipeline flush
- redirect_valid  out  1  one-cycle front-end redirect strobe
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE, counter=0. All outputs 0 except commit_ready=1.
- int_pending = crmd_ie & |(ecfg_lie & estat_is), combinational from current inputs.
- States:
  - IDLE: commit_ready=1.
  - FLUSH: commit_ready=0; all commit_* inputs ignored.
- Accept condition: IDLE & commit_valid & (int_pending | commit_exc_valid | commit_is_ertn). Event priority, highest first:
  - Interrupt: cause=`EXCEPTION_INT, pc=commit_pc, addr=0. The instruction is not executed.
  - Instruction exception: cause=commit_exc_cause, pc=commit_pc, addr=commit_exc_addr.
  - ertn.
- Simultaneous exc_valid and is_ertn: treated as exception; no is_ertn pulse.
- All outputs are registered. On the edge after acceptance:
  - Exception: is_exception=1, is_ertn=0.
  - ertn: is_ertn=1, is_exception=0.
  - exception_cause/pc/addr hold the selected values; they are held until the next accepted event.
  - flush=1, redirect_valid=1.
  - redirect_pc = `EXCEPTION_TLBR ? tlbrentry_pa : exception ? {eentry_va[31:6],6'b0} : era_pc. Values are sampled in the acceptance cycle.
  - FSM goes to FLUSH with counter=FLUSH_CYCLES-1.
- Pulse widths:
  - is_exception, is_ertn and redirect_valid are exactly one cycle wide.
  - flush is high for exactly FLUSH_CYCLES cycles.
- In FLUSH: counter decrements each cycle. When counter==0 the next state is IDLE and flush drops on that edge. With FLUSH_CYCLES=1 the FSM spends one cycle in FLUSH.
- Minimum spacing between accepted events: FLUSH_CYCLES+1 cycles.
- commit_valid with no event: passes through; no outputs change.
- Interrupt that appears while in FLUSH: not latched. It is re-evaluated at the first IDLE commit.
- int_pending with commit_valid=0: no action; interrupts are taken only on an instruction boundary.
- Reset mid-FLUSH: immediate return to IDLE; flush and pulses clear asynchronously.

Test Plan:
- Syscall: commit_valid=1, exc_valid=1, cause=`EXCEPTION_SYS, pc=0x1c000100, eentry_va=0x1c008040 → next cycle: is_exception=1, exception_pc=0x1c000100, redirect_pc=0x1c008040; flush high 2 cycles; commit_ready=0 for 2 cycles.
- Interrupt priority: crmd_ie=1, ecfg_lie=0x800, estat_is=0x800, same commit also exc_valid=1 cause=`EXCEPTION_INE → cause=`EXCEPTION_INT, addr=0. With crmd_ie=0 the INE exception is taken instead.
- TLB refill: cause=`EXCEPTION_TLBR, exc_addr=0x00400000, tlbrentry_pa=0x1c00f000 → exception_addr=0x00400000, redirect_pc=0x1c00f000.
- ertn: commit_is_ertn=1, era_pc=0x1c000204 → is_ertn=1 for one cycle, is_exception=0, redirect_pc=0x1c000204. ertn together with exc_valid → is_exception only.
- Back-to-back: exception commits every cycle → accepted events spaced 3 cycles apart (FLUSH_CYCLES=2). Commits offered during FLUSH produce no pulses.
- Async reset: assert rst_n=0 mid-FLUSH between clock edges → flush=0, redirect_valid=0, commit_ready=1 immediately. After release, the first exception commit behaves exactly as the syscall scenario.

Source files
------------

// File: rtl/exception_ctrl.sv
// Commit-stage exception/interrupt sequencer: picks one event per instruction boundary, pulses CSR update, flushes and redirects.
// Latency: all outputs registered, one cycle after the accepting commit; flush then lasts FLUSH_CYCLES cycles.
// Backpressure: commit_ready drops for the whole flush window; commits offered then are ignored, not queued.
`ifndef EXCEPTION_INT
`define EXCEPTION_INT  7'h00
`endif
`ifndef EXCEPTION_TLBR
`define EXCEPTION_TLBR 7'h3f
`endif

module exception_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CAUSE_W      = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               commit_valid,
    input  logic [31:0]        commit_pc,
    input  logic               commit_exc_valid,
    input  logic [CAUSE_W-1:0] commit_exc_cause,
    input  logic [31:0]        commit_exc_addr,
    input  logic               commit_is_ertn,
    output logic               commit_ready,
    input  logic               crmd_ie,
    input  logic [11:0]        ecfg_lie,
    input  logic [11:0]        estat_is,
    input  logic [31:0]        eentry_va,
    input  logic [31:0]        tlbrentry_pa,
    input  logic [31:0]        era_pc,
    output logic               is_exception,
    output logic [CAUSE_W-1:0] exception_cause,
    output logic [31:0]        exception_pc,
    output logic [31:0]        exception_addr,
    output logic               is_ertn,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0]         FLUSH_CNT  = 4'(FLUSH_CYCLES - 1);
    localparam logic [CAUSE_W-1:0] CAUSE_INT  = CAUSE_W'(`EXCEPTION_INT);
    localparam logic [CAUSE_W-1:0] CAUSE_TLBR = CAUSE_W'(`EXCEPTION_TLBR);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               flush_d, is_exc_d, is_ertn_d, rv_d;
    logic [CAUSE_W-1:0] cause_d;
    logic [31:0]        pc_d, addr_d, rpc_d;

    logic               int_pending, take_exc, accept;
    logic [CAUSE_W-1:0] sel_cause;
    logic [31:0]        sel_addr, sel_target;

    assign int_pending = crmd_ie & |(ecfg_lie & estat_is);
    assign take_exc    = int_pending | commit_exc_valid;
    assign accept      = (state_q == IDLE) & commit_valid & (take_exc | commit_is_ertn);

    // An interrupt pre-empts the instruction, so its own exception status is dropped.
    assign sel_cause = int_pending ? CAUSE_INT : commit_exc_cause;
    assign sel_addr  = int_pending ? 32'h0 : commit_exc_addr;

    always_comb begin
        sel_target = era_pc;
        if (take_exc) begin
            if (sel_cause == CAUSE_TLBR) sel_target = tlbrentry_pa;
            else                         sel_target = {eentry_va[31:6], 6'b0};
        end
    end

    assign commit_ready = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_d   = 1'b0;
        is_exc_d  = 1'b0;
        is_ertn_d = 1'b0;
        rv_d      = 1'b0;
        cause_d   = exception_cause;
        pc_d      = exception_pc;
        addr_d    = exception_addr;
        rpc_d     = redirect_pc;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = FLUSH;
                    cnt_d     = FLUSH_CNT;
                    flush_d   = 1'b1;
                    rv_d      = 1'b1;
                    rpc_d     = sel_target;
                    is_exc_d  = take_exc;
                    is_ertn_d = ~take_exc;
                    if (take_exc) begin
                        cause_d = sel_cause;
                        pc_d    = commit_pc;
                        addr_d  = sel_addr;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= 4'd0;
            flush           <= 1'b0;
            is_exception    <= 1'b0;
            is_ertn         <= 1'b0;
            redirect_valid  <= 1'b0;
            exception_cause <= '0;
            exception_pc    <= 32'h0;
            exception_addr  <= 32'h0;
            redirect_pc     <= 32'h0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            flush           <= flush_d;
            is_exception    <= is_exc_d;
            is_ertn         <= is_ertn_d;
            redirect_valid  <= rv_d;
            exception_cause <= cause_d;
            exception_pc    <= pc_d;
            exception_addr  <= addr_d;
            redirect_pc     <= rpc_d;
        end
    end

endmodule
